core_memory_arbiter: RTL

CORE_MEMORY_ARBITER -- requirements
Module: core_memory_arbiter

---
 rtl/core_memory_pkg.sv | 41 ++++
 rtl/memory_region_decoder.sv | 27 ++
 rtl/core_memory_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_memory_pkg.sv
// ----------------------------------------------------------------------------
// core_memory_pkg
// Shared definitions for the core memory arbiter:
//   - arb_state_e        : arbiter FSM states (IDLE / ISSUE_x / RESP_x)
//   - ENC_IDLE, ENC_RESP_*: fixed encodings of the idle and response states
//   - REGION_*_TAG       : address bits [31:24] values that map onto the SRAM
//   - addr_in_region()   : region test used by the per-port decoders
//   - state_is_resp()    : true in either response state
// ----------------------------------------------------------------------------
package core_memory_pkg;

    // Only these two top-byte windows alias onto the SRAM; everything else
    // is reported back to the requester as an access fault.
    localparam logic [7:0] REGION_LOW_TAG  = 8'h00;
    localparam logic [7:0] REGION_HIGH_TAG = 8'h80;

    localparam logic [2:0] ENC_IDLE       = 3'd0;
    localparam logic [2:0] ENC_RESP_INSTR = 3'd3;
    localparam logic [2:0] ENC_RESP_DATA  = 3'd4;

    typedef enum logic [2:0] {
        IDLE        = ENC_IDLE,
        ISSUE_INSTR = 3'd1,
        ISSUE_DATA  = 3'd2,
        RESP_INSTR  = ENC_RESP_INSTR,
        RESP_DATA   = ENC_RESP_DATA
    } arb_state_e;

    // Index of each requester in per-port arrays.
    localparam int PORT_INSTR = 0;
    localparam int PORT_DATA  = 1;

    function automatic logic addr_in_region(input logic [31:0] addr);
        return (addr[31:24] == REGION_LOW_TAG) || (addr[31:24] == REGION_HIGH_TAG);
    endfunction

    function automatic logic state_is_resp(input arb_state_e s);
        return (s == RESP_INSTR) || (s == RESP_DATA);
    endfunction

endpackage

// File: rtl/memory_region_decoder.sv
// ----------------------------------------------------------------------------
// memory_region_decoder
// Classifies a 32-bit byte address as SRAM-backed or faulting and extracts the
// SRAM word address (byte offset dropped, region tag dropped).
// Ports:
//   address_i       in  32                      requester byte address
//   in_region_o     out 1                       address maps onto the SRAM
//   local_address_o out LOCAL_ADDRESS_WIDTH-2   SRAM word address
// ----------------------------------------------------------------------------
module memory_region_decoder
    import core_memory_pkg::*;
#(
    parameter int LOCAL_ADDRESS_WIDTH = 24
) (
    input  logic [31:0]                    address_i,
    output logic                           in_region_o,
    output logic [LOCAL_ADDRESS_WIDTH-3:0] local_address_o
);

    // The SRAM is word-wide; byte lanes are chosen by byte select instead.
    logic unused_byte_offset;

    assign in_region_o        = addr_in_region(address_i);
    assign local_address_o    = address_i[LOCAL_ADDRESS_WIDTH-1:2];
    assign unused_byte_offset = ^address_i[1:0];

endmodule

// File: rtl/core_memory_arbiter.sv
// ----------------------------------------------------------------------------
// core_memory_arbiter
// Shares one single-port synchronous SRAM between an instruction-fetch port
// and a load/store data port. Every access takes exactly two cycles from
// grant to its response cycle: grant (IDLE or RESP_x) -> ISSUE_x -> RESP_x.
// A new grant may be taken in a RESP cycle, so held requests stream
// back-to-back with one response every two cycles.
//
// Configuration:
//   MEM_ARB_ROUND_ROBIN_EN  defined   : simultaneous requests alternate,
//                                       starting with the data port.
//                           undefined : data port always wins a tie.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   instruction_memoryAddress  in  32  fetch byte address
//   instruction_memoryEnable   in  1   fetch request (held until done)
//   instruction_memoryDataRead out 32  fetch data, valid in RESP_INSTR
//   instruction_memoryBusy     out 1   request pending, not yet answered
//   instruction_memoryAccessFault out 1 out-of-region fetch (RESP cycle)
//   data_memoryAddress         in  32  load/store byte address
//   data_memoryByteSelect      in  4   byte lanes for stores
//   data_memoryEnable          in  1   load/store request
//   data_memoryWriteEnable     in  1   1 = store
//   data_memoryDataWrite       in  32  store data
//   data_memoryDataRead        out 32  load data, valid in RESP_DATA
//   data_memoryBusy            out 1
//   data_memoryAccessFault     out 1
//   sram_enable/writeEnable/byteSelect/address/dataWrite  SRAM command
//   sram_dataRead              in  32  SRAM read data, one cycle after read
// ----------------------------------------------------------------------------
module core_memory_arbiter
    import core_memory_pkg::*;
#(
    parameter int SRAM_ADDRESS_WIDTH = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [31:0]                   instruction_memoryAddress,
    input  logic                          instruction_memoryEnable,
    output logic [31:0]                   instruction_memoryDataRead,
    output logic                          instruction_memoryBusy,
    output logic                          instruction_memoryAccessFault,

    input  logic [31:0]                   data_memoryAddress,
    input  logic [3:0]                    data_memoryByteSelect,
    input  logic                          data_memoryEnable,
    input  logic                          data_memoryWriteEnable,
    input  logic [31:0]                   data_memoryDataWrite,
    output logic [31:0]                   data_memoryDataRead,
    output logic                          data_memoryBusy,
    output logic                          data_memoryAccessFault,

    output logic                          sram_enable,
    output logic                          sram_writeEnable,
    output logic [3:0]                    sram_byteSelect,
    output logic [SRAM_ADDRESS_WIDTH-3:0] sram_address,
    output logic [31:0]                   sram_dataWrite,
    input  logic [31:0]                   sram_dataRead
);

    localparam int WA = SRAM_ADDRESS_WIDTH - 2;

    // ------------------------------------------------------------------
    // Per-port address decode
    // ------------------------------------------------------------------
    logic [31:0]   port_addr      [2];
    logic [1:0]    port_in_region;
    logic [WA-1:0] port_word      [2];

    assign port_addr[PORT_INSTR] = instruction_memoryAddress;
    assign port_addr[PORT_DATA]  = data_memoryAddress;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_decode
            memory_region_decoder #(
                .LOCAL_ADDRESS_WIDTH(SRAM_ADDRESS_WIDTH)
            ) u_decoder (
                .address_i      (port_addr[gi]),
                .in_region_o    (port_in_region[gi]),
                .local_address_o(port_word[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------
    arb_state_e    state_q, state_d;
    logic [WA-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          fault_q, fault_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 when the most recent grant went to the data port. Cleared at reset
    // so that the first tie goes to data.
    logic last_data_q, last_data_d;
`endif

    logic grant_instr;
    logic grant_data;
    logic grant_any;
    logic can_grant;

    // Selected request, valid only in a grant cycle.
    logic [WA-1:0] sel_addr;
    logic [3:0]    sel_be;
    logic          sel_we;
    logic [31:0]   sel_wdata;
    logic          sel_fault;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        grant_instr = 1'b0;
        grant_data  = 1'b0;
        // Gating with rst_n keeps the combinational grant path (and so the
        // SRAM address/data) quiet while reset is held.
        can_grant   = rst_n && ((state_q == IDLE) || state_is_resp(state_q));

        if (can_grant) begin
            if (data_memoryEnable && instruction_memoryEnable) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (last_data_q) begin
                    grant_instr = 1'b1;
                end else begin
                    grant_data = 1'b1;
                end
`else
                grant_data = 1'b1;
`endif
            end else if (data_memoryEnable) begin
                grant_data = 1'b1;
            end else if (instruction_memoryEnable) begin
                grant_instr = 1'b1;
            end
        end
        grant_any = grant_instr | grant_data;
    end

    always_comb begin
        sel_addr  = port_word[PORT_INSTR];
        sel_be    = 4'b1111;
        sel_we    = 1'b0;
        sel_wdata = 32'h0;
        sel_fault = ~port_in_region[PORT_INSTR];
        if (grant_data) begin
            sel_addr  = port_word[PORT_DATA];
            sel_be    = data_memoryByteSelect;
            sel_we    = data_memoryWriteEnable;
            sel_wdata = data_memoryDataWrite;
            sel_fault = ~port_in_region[PORT_DATA];
        end
    end

    // ------------------------------------------------------------------
    // Next state and request capture
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        fault_d = fault_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_data_d = last_data_q;
`endif

        case (state_q)
            IDLE, RESP_INSTR, RESP_DATA: begin
                if (grant_data) begin
                    state_d = ISSUE_DATA;
                end else if (grant_instr) begin
                    state_d = ISSUE_INSTR;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE_INSTR: state_d = RESP_INSTR;
            ISSUE_DATA:  state_d = RESP_DATA;
            default:     state_d = IDLE;
        endcase

        if (grant_any) begin
            addr_d  = sel_addr;
            be_d    = sel_be;
            we_d    = sel_we;
            wdata_d = sel_wdata;
            fault_d = sel_fault;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data_d = grant_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_data_q <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // SRAM command
    // In the grant cycle the address/lanes/data already follow the selected
    // port, but the strobe stays low: the access is only committed in ISSUE
    // from the captured copy. That way a reset arriving before ISSUE ends
    // never lets a write reach the array, and the first cycle after reset
    // release (always IDLE) can never write.
    // ------------------------------------------------------------------
    always_comb begin
        sram_enable      = 1'b0;
        sram_writeEnable = 1'b0;
        sram_byteSelect  = 4'b0000;
        sram_address     = '0;
        sram_dataWrite   = 32'h0;

        if (grant_any) begin
            sram_byteSelect = sel_be;
            sram_address    = sel_addr;
            sram_dataWrite  = sel_wdata;
        end else if ((state_q == ISSUE_INSTR) || (state_q == ISSUE_DATA)) begin
            sram_enable      = ~fault_q;
            sram_writeEnable = we_q & ~fault_q;
            sram_byteSelect  = be_q;
            sram_address     = addr_q;
            sram_dataWrite   = wdata_q;
        end
    end

    // ------------------------------------------------------------------
    // Requester responses
    // Read data is forwarded only for successful reads in the owning port's
    // response cycle; stores and faults return zero.
    // ------------------------------------------------------------------
    always_comb begin
        instruction_memoryBusy        = instruction_memoryEnable && (state_q != RESP_INSTR);
        data_memoryBusy               = data_memoryEnable && (state_q != RESP_DATA);
        instruction_memoryAccessFault = (state_q == RESP_INSTR) && fault_q;
        data_memoryAccessFault        = (state_q == RESP_DATA) && fault_q;
        instruction_memoryDataRead    = 32'h0;
        data_memoryDataRead           = 32'h0;

        if ((state_q == RESP_INSTR) && !fault_q) begin
            instruction_memoryDataRead = sram_dataRead;
        end
        if ((state_q == RESP_DATA) && !fault_q && !we_q) begin
            data_memoryDataRead = sram_dataRead;
        end
    end

endmodule
